// File: rtl/trace_pkg.sv
// Shared types for the commit trace buffer: the record format handed to the
// reference-model checker and a saturating adder for the drop counter.
package trace_pkg;

   localparam int TRACE_LANES_MAX = 4;

   typedef struct packed {
      logic [63:0] seq;
      logic [63:0] pc;
      logic [31:0] ir;
      logic [1:0]  level;
      logic        gprw;
      logic [5:0]  gpra;
      logic [63:0] gprv;
      logic        mexc;
      logic        sexc;
      logic        intr;
      logic        ret;
   } trace_rec_t;

   // 64-bit add that sticks at all-ones instead of wrapping.
   function automatic logic [63:0] sat_add64(input logic [63:0] a, input logic [63:0] b);
      logic [64:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[64] ? {64{1'b1}} : sum[63:0];
   endfunction

endpackage

// File: rtl/commit_trace_buffer_mwpram.sv
// Multi-write-port RAM with combinational read ports. Contents have no reset:
// only the pointers that reference them are cleared.
module mwpram #(
   parameter int width  = 32,
   parameter int depth  = 64,
   parameter int rports = 1,
   parameter int wports = 4
) (
   input  logic                                   i_clk,
   input  logic [wports-1:0]                      i_we,
   input  logic [wports-1:0][$clog2(depth)-1:0]   i_waddr,
   input  logic [wports-1:0][width-1:0]           i_wdata,
   input  logic [rports-1:0][$clog2(depth)-1:0]   i_raddr,
   output logic [rports-1:0][width-1:0]           o_rdata
);

   logic [width-1:0] r_mem [depth];

   // Write every enabled port; callers guarantee distinct addresses per cycle.
   always_ff @(posedge i_clk) begin
      for (int k = 0; k < wports; k++) begin
         if (i_we[k]) begin
            r_mem[i_waddr[k]] <= i_wdata[k];
         end
      end
   end

   // Fall-through read so the head slot is visible without a read cycle.
   always_comb begin
      for (int p = 0; p < rports; p++) begin
         o_rdata[p] = r_mem[i_raddr[p]];
      end
   end

endmodule

// File: rtl/commit_trace_buffer.sv
// Captures up to `lanes` commits per cycle, packs them in program order with a
// global sequence number, and drains them one per cycle over valid/ready.
// The core cannot stall, so excess records are counted and dropped, and a
// watchdog flags a core that has stopped committing.
module commit_trace_buffer
   import trace_pkg::*;
#(
   parameter int lanes   = 4,
   parameter int depth   = 64,
   parameter int timeout = 4096
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic [lanes-1:0]            i_cmt,
   input  logic [lanes-1:0][1:0]       i_cmt_level,
   input  logic [lanes-1:0][63:0]      i_cmt_pc,
   input  logic [lanes-1:0][31:0]      i_cmt_ir,
   input  logic [lanes-1:0]            i_del_gprw,
   input  logic [lanes-1:0][5:0]       i_del_gpra,
   input  logic [lanes-1:0][63:0]      i_del_gprv,
   input  logic                        i_cmt_mexc,
   input  logic                        i_cmt_sexc,
   input  logic                        i_cmt_int,
   input  logic                        i_cmt_ret,
   input  logic [63:0]                 i_stallpc,
   output logic                        o_out_valid,
   input  logic                        i_out_ready,
   output trace_rec_t                  o_out_rec,
   output logic [$clog2(depth):0]      o_count,
   output logic [63:0]                 o_drops,
   output logic                        o_ovf,
   output logic                        o_hang,
   output logic [63:0]                 o_hang_pc
);

   localparam int AW = $clog2(depth);
   localparam int CW = AW + 1;
   localparam int IW = $clog2(timeout + 1);

   logic [CW-1:0]              r_wptr;
   logic [CW-1:0]              r_rptr;
   logic [63:0]                r_seq_nxt;
   logic [63:0]                r_drops;
   logic                       r_ovf;
   logic [IW-1:0]              r_idle;
   logic                       r_hang;
   logic [63:0]                r_hang_pc;

   logic [CW-1:0]              w_count;
   logic [CW-1:0]              w_free;
   logic [CW-1:0]              w_n;
   logic [CW-1:0]              w_written;
   logic [CW-1:0]              w_dropped;
   logic [lanes-1:0][CW-1:0]   w_pos;
   logic                       w_pop;
   logic                       w_any;
   trace_rec_t [lanes-1:0]     w_lane_rec;
   trace_rec_t [lanes-1:0]     w_slot_rec;
   logic [lanes-1:0]           w_we;
   logic [lanes-1:0][AW-1:0]   w_waddr;
   logic [0:0][AW-1:0]         w_raddr;
   logic [0:0][$bits(trace_rec_t)-1:0] w_rdata;

   assign w_count   = r_wptr - r_rptr;
   assign w_free    = CW'(depth) - w_count;
   assign w_any     = |i_cmt;
   assign w_pop     = (w_count != {CW{1'b0}}) & i_out_ready;
   assign w_written = (w_n <= w_free) ? w_n : w_free;
   assign w_dropped = w_n - w_written;
   assign w_raddr[0] = r_rptr[AW-1:0];

   // Slot index of each lane = number of committing lanes below it.
   always_comb begin
      logic [CW-1:0] w_acc;
      w_acc = {CW{1'b0}};
      for (int l = 0; l < lanes; l++) begin
         w_pos[l] = w_acc;
         w_acc    = w_acc + CW'(i_cmt[l]);
      end
      w_n = w_acc;
   end

   // Build each lane's record; event flags belong to lane 0 only.
   always_comb begin
      for (int l = 0; l < lanes; l++) begin
         w_lane_rec[l].seq   = r_seq_nxt + 64'(w_pos[l]);
         w_lane_rec[l].pc    = i_cmt_pc[l];
         w_lane_rec[l].ir    = i_cmt_ir[l];
         w_lane_rec[l].level = i_cmt_level[l];
         w_lane_rec[l].gprw  = i_del_gprw[l];
         w_lane_rec[l].gpra  = i_del_gpra[l];
         w_lane_rec[l].gprv  = i_del_gprv[l];
         if (l == 0) begin
            w_lane_rec[l].mexc = i_cmt_mexc;
            w_lane_rec[l].sexc = i_cmt_sexc;
            w_lane_rec[l].intr = i_cmt_int;
            w_lane_rec[l].ret  = i_cmt_ret;
         end else begin
            w_lane_rec[l].mexc = 1'b0;
            w_lane_rec[l].sexc = 1'b0;
            w_lane_rec[l].intr = 1'b0;
            w_lane_rec[l].ret  = 1'b0;
         end
      end
   end

   // Compact committing lanes into consecutive write slots and gate by space.
   always_comb begin
      trace_rec_t    w_sel;
      logic [CW-1:0] w_addr_sum;
      for (int s = 0; s < lanes; s++) begin
         w_sel = '0;
         for (int l = 0; l < lanes; l++) begin
            if (i_cmt[l] && (w_pos[l] == CW'(s))) begin
               w_sel = w_lane_rec[l];
            end else begin
               w_sel = w_sel;
            end
         end
         w_slot_rec[s] = w_sel;
         w_we[s]       = CW'(s) < w_written;
         w_addr_sum    = r_wptr + CW'(s);
         w_waddr[s]    = w_addr_sum[AW-1:0];
      end
   end

   mwpram #(
      .width  ($bits(trace_rec_t)),
      .depth  (depth),
      .rports (1),
      .wports (lanes)
   ) u_ram (
      .i_clk   (i_clk),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (w_slot_rec),
      .i_raddr (w_raddr),
      .o_rdata (w_rdata)
   );

   // Pointers, sequence numbering and overflow accounting.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wptr    <= {CW{1'b0}};
         r_rptr    <= {CW{1'b0}};
         r_seq_nxt <= 64'd0;
         r_drops   <= 64'd0;
         r_ovf     <= 1'b0;
      end else begin
         r_wptr    <= r_wptr + w_written;
         r_rptr    <= r_rptr + CW'(w_pop);
         r_seq_nxt <= r_seq_nxt + 64'(w_n);
         r_drops   <= sat_add64(r_drops, 64'(w_dropped));
         if (w_dropped != {CW{1'b0}}) begin
            r_ovf <= 1'b1;
         end
      end
   end

   // Commit-hang watchdog: counts idle cycles, latches the stall PC once.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_idle    <= {IW{1'b0}};
         r_hang    <= 1'b0;
         r_hang_pc <= 64'd0;
      end else if (w_any) begin
         r_idle <= {IW{1'b0}};
      end else if (r_idle < IW'(timeout)) begin
         r_idle <= r_idle + IW'(1);
         if ((r_idle == IW'(timeout - 1)) && !r_hang) begin
            r_hang    <= 1'b1;
            r_hang_pc <= i_stallpc;
         end
      end
   end

   assign o_out_valid = (w_count != {CW{1'b0}});
   assign o_out_rec   = trace_rec_t'(w_rdata[0]);
   assign o_count     = w_count;
   assign o_drops     = r_drops;
   assign o_ovf       = r_ovf;
   assign o_hang      = r_hang;
   assign o_hang_pc   = r_hang_pc;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Randomized bench for commit_trace_buffer against a queue-based reference
// model, plus directed scenarios for sparse lanes, overflow and the watchdog.
module tb_commit_trace_buffer;
   import trace_pkg::*;

   localparam int LANES = 4;
   localparam int DEPTH = 64;
   localparam int TMO   = 16;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic [LANES-1:0]       cmt;
   logic [LANES-1:0][1:0]  lvl;
   logic [LANES-1:0][63:0] pc;
   logic [LANES-1:0][31:0] ir;
   logic [LANES-1:0]       gprw;
   logic [LANES-1:0][5:0]  gpra;
   logic [LANES-1:0][63:0] gprv;
   logic                   mexc, sexc, intr, ret;
   logic [63:0]            stallpc;
   logic                   ready;

   logic                   o_valid;
   trace_rec_t             o_rec;
   logic [6:0]             o_count;
   logic [63:0]            o_drops;
   logic                   o_ovf;
   logic                   o_hang;
   logic [63:0]            o_hang_pc;

   int checks = 0;
   int errors = 0;

   trace_rec_t  m_q[$];
   logic [63:0] m_seq;
   logic [63:0] m_drops;
   logic        m_ovf;
   int          m_idle;
   logic        m_hang;
   logic [63:0] m_hang_pc;

   always #5 clk = ~clk;

   commit_trace_buffer #(.lanes(LANES), .depth(DEPTH), .timeout(TMO)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_cmt       (cmt),
      .i_cmt_level (lvl),
      .i_cmt_pc    (pc),
      .i_cmt_ir    (ir),
      .i_del_gprw  (gprw),
      .i_del_gpra  (gpra),
      .i_del_gprv  (gprv),
      .i_cmt_mexc  (mexc),
      .i_cmt_sexc  (sexc),
      .i_cmt_int   (intr),
      .i_cmt_ret   (ret),
      .i_stallpc   (stallpc),
      .o_out_valid (o_valid),
      .i_out_ready (ready),
      .o_out_rec   (o_rec),
      .o_count     (o_count),
      .o_drops     (o_drops),
      .o_ovf       (o_ovf),
      .o_hang      (o_hang),
      .o_hang_pc   (o_hang_pc)
   );

   task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_seq     = 64'd0;
      m_drops   = 64'd0;
      m_ovf     = 1'b0;
      m_idle    = 0;
      m_hang    = 1'b0;
      m_hang_pc = 64'd0;
   endtask

   // One clock of the reference model, using the inputs presented at the edge.
   task automatic model_step();
      int free;
      trace_rec_t r;
      free = DEPTH - m_q.size();
      if ((m_q.size() != 0) && ready) void'(m_q.pop_front());
      for (int l = 0; l < LANES; l++) begin
         if (cmt[l]) begin
            r.seq   = m_seq;
            r.pc    = pc[l];
            r.ir    = ir[l];
            r.level = lvl[l];
            r.gprw  = gprw[l];
            r.gpra  = gpra[l];
            r.gprv  = gprv[l];
            r.mexc  = (l == 0) ? mexc : 1'b0;
            r.sexc  = (l == 0) ? sexc : 1'b0;
            r.intr  = (l == 0) ? intr : 1'b0;
            r.ret   = (l == 0) ? ret  : 1'b0;
            if (free > 0) begin
               m_q.push_back(r);
               free--;
            end else begin
               if (m_drops != {64{1'b1}}) m_drops = m_drops + 64'd1;
               m_ovf = 1'b1;
            end
            m_seq = m_seq + 64'd1;
         end
      end
      if (|cmt) begin
         m_idle = 0;
      end else if (m_idle < TMO) begin
         m_idle++;
         if ((m_idle == TMO) && !m_hang) begin
            m_hang    = 1'b1;
            m_hang_pc = stallpc;
         end
      end
   endtask

   task automatic compare_all();
      check_val("valid", o_valid, (m_q.size() != 0));
      check_val("count", o_count, m_q.size());
      if (m_q.size() != 0) check_val("rec", o_rec, m_q[0]);
      check_val("drops", o_drops, m_drops);
      check_val("ovf", o_ovf, m_ovf);
      check_val("hang", o_hang, m_hang);
      check_val("hang_pc", o_hang_pc, m_hang_pc);
   endtask

   // Called at posedge+1 with inputs set; returns at the next posedge+1.
   task automatic cycle();
      @(negedge clk);
      compare_all();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic set_quiet();
      cmt  = '0;
      mexc = 1'b0;
      sexc = 1'b0;
      intr = 1'b0;
      ret  = 1'b0;
   endtask

   task automatic randomize_payload();
      for (int l = 0; l < LANES; l++) begin
         pc[l]   = {$urandom, $urandom};
         ir[l]   = $urandom;
         lvl[l]  = 2'($urandom);
         gprw[l] = 1'($urandom);
         gpra[l] = 6'($urandom);
         gprv[l] = {$urandom, $urandom};
      end
      mexc    = 1'($urandom);
      sexc    = 1'($urandom);
      intr    = 1'($urandom);
      ret     = 1'($urandom);
      stallpc = {$urandom, $urandom};
   endtask

   // Asynchronous reset asserted mid-cycle; the release cycle is a model step.
   task automatic do_reset();
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      check_val("rst_valid", o_valid, 1'b0);
      check_val("rst_count", o_count, 7'd0);
      check_val("rst_drops", o_drops, 64'd0);
      check_val("rst_ovf", o_ovf, 1'b0);
      check_val("rst_hang", o_hang, 1'b0);
      check_val("rst_hang_pc", o_hang_pc, 64'd0);
      model_reset();
      set_quiet();
      ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      model_step();
      #1;
   endtask

   initial begin
      int mode;
      set_quiet();
      ready   = 1'b0;
      stallpc = 64'd0;
      randomize_payload();
      set_quiet();
      model_reset();
      do_reset();

      // Single commit with immediate drain.
      cmt = 4'b0001; pc[0] = 64'h8000_0000; ir[0] = 32'h0000_0013; ready = 1'b1;
      cycle();
      set_quiet();
      check_val("single_valid", o_valid, 1'b1);
      check_val("single_seq", o_rec.seq, 64'd0);
      check_val("single_pc", o_rec.pc, 64'h8000_0000);
      cycle();
      check_val("single_drained", o_count, 7'd0);

      // Sparse lanes 0,2,3 pack in order.
      do_reset();
      randomize_payload();
      mexc = 1'b0;
      cmt = 4'b1101; ready = 1'b0;
      pc[0] = 64'h100; pc[1] = 64'h111; pc[2] = 64'h200; pc[3] = 64'h300;
      cycle();
      set_quiet();
      check_val("sparse_count", o_count, 7'd3);
      check_val("sparse_pc0", o_rec.pc, 64'h100);
      ready = 1'b1;
      cycle();
      check_val("sparse_pc1", o_rec.pc, 64'h200);
      check_val("sparse_seq1", o_rec.seq, 64'd1);
      cycle();
      check_val("sparse_pc2", o_rec.pc, 64'h300);
      check_val("sparse_seq2", o_rec.seq, 64'd2);
      cycle();

      // Overflow: 17 cycles of 4 commits into a stalled consumer.
      do_reset();
      ready = 1'b0;
      for (int c = 0; c < 17; c++) begin
         randomize_payload();
         cmt = 4'b1111;
         cycle();
      end
      set_quiet();
      check_val("ovf_count", o_count, 7'd64);
      check_val("ovf_drops", o_drops, 64'd4);
      check_val("ovf_flag", o_ovf, 1'b1);
      ready = 1'b1;
      cycle();
      ready = 1'b0;
      randomize_payload();
      cmt = 4'b0001;
      cycle();
      set_quiet();
      check_val("ovf_refill", o_count, 7'd64);
      ready = 1'b1;
      for (int c = 0; c < 63; c++) cycle();
      check_val("ovf_last_count", o_count, 7'd1);
      check_val("ovf_next_seq", o_rec.seq, 64'd68);
      cycle();

      // Full buffer with same-cycle pop still writes nothing.
      do_reset();
      ready = 1'b0;
      for (int c = 0; c < 16; c++) begin
         randomize_payload();
         cmt = 4'b1111;
         cycle();
      end
      check_val("full_count", o_count, 7'd64);
      randomize_payload();
      cmt = 4'b0001; ready = 1'b1;
      cycle();
      set_quiet();
      check_val("fullpop_count", o_count, 7'd63);
      check_val("fullpop_drops", o_drops, 64'd1);

      // Exception flag only rides on a lane-0 commit.
      do_reset();
      randomize_payload();
      cmt = 4'b0001; mexc = 1'b1; ready = 1'b0;
      cycle();
      check_val("exc_tag", o_rec.mexc, 1'b1);
      cmt = 4'b0000; mexc = 1'b1; ready = 1'b1;
      cycle();
      check_val("exc_norec", o_count, 7'd0);
      cmt = 4'b0010; mexc = 1'b1; ready = 1'b0;
      cycle();
      check_val("exc_lane1", o_rec.mexc, 1'b0);
      set_quiet();

      // Watchdog: 16 idle cycles including the reset-release cycle.
      do_reset();
      stallpc = 64'h8000_1234;
      ready = 1'b1;
      for (int c = 0; c < 14; c++) cycle();
      check_val("wd_early", o_hang, 1'b0);
      cycle();
      check_val("wd_hang", o_hang, 1'b1);
      check_val("wd_pc", o_hang_pc, 64'h8000_1234);
      randomize_payload();
      cmt = 4'b0001;
      cycle();
      set_quiet();
      check_val("wd_sticky", o_hang, 1'b1);
      do_reset();
      check_val("wd_cleared", o_hang, 1'b0);

      // Randomized traffic in changing regimes with a reset mid-run.
      mode = 0;
      for (int c = 0; c < 3000; c++) begin
         if ((c % 200) == 0) mode = $urandom_range(0, 2);
         if (c == 1500) do_reset();
         randomize_payload();
         case (mode)
            0: begin
               cmt   = LANES'($urandom);
               ready = ($urandom_range(0, 3) != 0);
            end
            1: begin
               cmt   = ($urandom_range(0, 3) != 0) ? 4'b1111 : LANES'($urandom);
               ready = ($urandom_range(0, 3) == 0);
            end
            default: begin
               cmt   = ($urandom_range(0, 19) == 0) ? LANES'($urandom) : 4'b0000;
               ready = 1'b1;
            end
         endcase
         cycle();
      end
      set_quiet();
      cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
